// File: rtl/uart_rx_decoder.sv
// rtl/uart_rx_decoder.sv - 8N1 UART receiver with a byte FIFO behind a valid/ready handshake
module uart_rx_decoder #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        io_mainClk,
    input  logic                        io_asyncReset,
    input  logic                        io_uart_rxd,
    output logic [7:0]                  io_data,
    output logic                        io_valid,
    input  logic                        io_ready,
    output logic [$clog2(FIFO_DEPTH):0] io_count,
    output logic                        io_frameError,
    output logic                        io_overflow,
    input  logic                        io_clearErrors
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_frame_err;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_overflow;

    logic          w_rxs;
    logic          w_cnt_last;
    logic          w_push;
    logic [AW:0]   w_count;
    logic          w_full;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_drop;

    assign w_rxs      = r_sync2;
    assign w_cnt_last = (r_cnt == LAST_CNT);

    // Push is decided combinationally at the stop sample so the byte lands in the same edge.
    assign w_push = (r_state == S_STOP) && w_cnt_last && w_rxs;

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= io_uart_rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_CNT) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_bit_idx <= '0;
                            r_state   <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_cnt_last) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == DEPTH);
    assign w_pop   = io_valid & io_ready;
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge io_mainClk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        end
    end

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (io_clearErrors) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign io_valid      = (w_count != '0);
    assign io_count      = w_count;
    assign io_data       = io_valid ? r_mem[r_rd_ptr[AW-1:0]] : 8'h00;
    assign io_frameError = r_frame_err;
    assign io_overflow   = r_overflow;

endmodule

// File: tb/tb_uart_rx_decoder.sv
// tb/tb_uart_rx_decoder.sv - self-checking bench for uart_rx_decoder
`timescale 1ns/1ps
module tb_uart_rx_decoder;
    localparam int C   = 16;
    localparam int D   = 4;
    localparam int LAT = 3 + C / 2 + 9 * C;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       ready;
    logic       clr;
    logic [7:0] data;
    logic       valid;
    logic [2:0] count;
    logic       ferr;
    logic       ovf;

    uart_rx_decoder #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .io_mainClk     (clk),
        .io_asyncReset  (rst),
        .io_uart_rxd    (rxd),
        .io_data        (data),
        .io_valid       (valid),
        .io_ready       (ready),
        .io_count       (count),
        .io_frameError  (ferr),
        .io_overflow    (ovf),
        .io_clearErrors (clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] d;
        logic       bad;
    } arr_t;

    typedef struct {
        logic [7:0] tdata;
        logic       stop_ok;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_count;
        int         exp_ferr;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         ferr_cnt = 0;
    int         base;
    int         pend_idx = 0;
    int         rate;
    int         gap;
    int         n;
    logic       mon_en = 1'b0;
    logic       rnd_done;
    logic       m_pop, m_push, m_perr, m_ferr = 1'b0, m_ovf = 1'b0;
    logic [7:0] m_pd;
    logic [7:0] rb;
    logic       rok;
    logic [7:0] m_q[$];
    arr_t       pend[$];
    vec_t       vecs[6];
    logic [7:0] exp_seq[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame model: the byte (or framing error) appears LAT edges after the start bit is driven.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        logic [9:0] bits;
        bits = {stop_ok, d, 1'b0};
        pend.push_back('{cyc + LAT, d, !stop_ok});
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            tick(C);
        end
        if (!stop_ok) begin
            rxd = 1'b1;
            tick(2);
        end
    endtask

    task automatic pop_one();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    task run_monitor();
        forever begin
            @(negedge clk);
            if (ferr) ferr_cnt++;
            if (!mon_en) begin
                m_q.delete();
                m_ovf    = 1'b0;
                m_ferr   = 1'b0;
                pend_idx = pend.size();
            end else begin
                n = m_q.size();
                check("valid", valid, n != 0);
                if (n != 0) check("data", data, m_q[0]);
                check("count", count, n);
                check("frame_error", ferr, m_ferr);
                check("overflow", ovf, m_ovf);
                m_pop  = (n != 0) && ready;
                m_push = 1'b0;
                m_perr = 1'b0;
                m_pd   = 8'h00;
                if (pend_idx < pend.size() && pend[pend_idx].at == cyc + 1) begin
                    if (pend[pend_idx].bad) m_perr = 1'b1;
                    else begin
                        m_push = 1'b1;
                        m_pd   = pend[pend_idx].d;
                    end
                    pend_idx++;
                end
                m_ferr = m_perr;
                if (m_pop) void'(m_q.pop_front());
                if (m_push && (n < D || m_pop)) m_q.push_back(m_pd);
                if (m_push && n == D && !m_pop) m_ovf = 1'b1;
                else if (clr) m_ovf = 1'b0;
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            run_monitor();
        join_none
        rst = 1'b1; rxd = 1'b1; ready = 1'b0; clr = 1'b0;
        vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1, 0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1, 0};
        vecs[2] = '{8'h55, 1'b1, 1'b1, 8'h55, 1, 0};
        vecs[3] = '{8'h12, 1'b0, 1'b0, 8'h00, 0, 1};
        vecs[4] = '{8'h34, 1'b1, 1'b1, 8'h34, 1, 0};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1, 0};
        tick(3);
        check("reset_valid", valid, 0);
        check("reset_count", count, 0);
        check("reset_data", data, 8'h00);
        check("reset_ferr", ferr, 0);
        check("reset_ovf", ovf, 0);
        rst = 1'b0;
        tick(1);
        mon_en = 1'b1;
        tick(4);

        fork
            send_frame(8'hA5, 1'b1);
            begin
                tick(LAT - 1);
                check("latency_before", valid, 0);
                tick(1);
                check("latency_valid", valid, 1);
                check("single_data", data, 8'hA5);
                check("single_count", count, 1);
            end
        join
        pop_one();
        check("single_pop_count", count, 0);
        check("single_pop_valid", valid, 0);

        for (int i = 0; i < 6; i++) begin
            base = ferr_cnt;
            send_frame(vecs[i].tdata, vecs[i].stop_ok);
            tick(4);
            check("vec_valid", valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) check("vec_data", data, vecs[i].exp_data);
            check("vec_count", count, vecs[i].exp_count);
            check("vec_ferr_pulses", ferr_cnt - base, vecs[i].exp_ferr);
            if (vecs[i].exp_valid) pop_one();
        end

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
        tick(2);
        check("b2b_count", count, 4);
        check("b2b_overflow", ovf, 1);
        exp_seq = '{8'h00, 8'hFF, 8'h55, 8'h3C};
        for (int i = 0; i < 4; i++) begin
            check("b2b_drain", data, exp_seq[i]);
            pop_one();
        end
        check("b2b_empty", valid, 0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clear_overflow", ovf, 0);

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        check("full_count", count, 4);
        fork
            send_frame(8'h77, 1'b1);
            begin
                tick(LAT - 1);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
                check("pushpop_full_count", count, 4);
                check("pushpop_full_ovf", ovf, 0);
            end
        join
        exp_seq = '{8'h22, 8'h33, 8'h44, 8'h77};
        for (int i = 0; i < 4; i++) begin
            check("pushpop_drain", data, exp_seq[i]);
            pop_one();
        end
        check("pushpop_empty", valid, 0);

        base = ferr_cnt;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(40);
        check("glitch_valid", valid, 0);
        check("glitch_ferr", ferr_cnt - base, 0);

        send_frame(8'h99, 1'b1);
        tick(2);
        check("prereset_count", count, 1);
        mon_en = 1'b0;
        rxd = 1'b0;
        tick(4 * C + 6);
        #2;
        rst = 1'b1;
        rxd = 1'b1;
        #1;
        check("midreset_valid", valid, 0);
        check("midreset_count", count, 0);
        check("midreset_data", data, 8'h00);
        check("midreset_ferr", ferr, 0);
        check("midreset_ovf", ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(20);
        mon_en = 1'b1;
        tick(1);
        send_frame(8'hC3, 1'b1);
        tick(2);
        check("postreset_valid", valid, 1);
        check("postreset_data", data, 8'hC3);
        pop_one();

        rnd_done = 1'b0;
        rate = 1;
        fork
            begin
                for (int k = 0; k < 14; k++) begin
                    rate = (k < 7) ? 1 : 60;
                    rb   = 8'($urandom_range(0, 255));
                    rok  = ($urandom_range(0, 5) != 0);
                    gap  = $urandom_range(0, 12);
                    send_frame(rb, rok);
                    tick(gap);
                end
                tick(10);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    ready = ($urandom_range(0, 255) < rate);
                    clr   = ($urandom_range(0, 9) == 0);
                end
            end
        join
        @(posedge clk);
        #1;
        ready = 1'b1;
        clr   = 1'b0;
        tick(8);
        ready = 1'b0;
        clr   = 1'b1;
        tick(1);
        clr = 1'b0;
        check("final_valid", valid, 0);
        check("final_count", count, 0);
        check("final_ovf", ovf, 0);
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_decoder.md
# uart_rx_decoder

Serial-to-byte receiver for the board side of the SoC's UART transmit line. It decodes the 8N1 frames that the Murax core drives on `io_uart_txd` into bytes and buffers them in a small FIFO with a valid/ready handshake. It feeds on-board consumers such as LED or debug logic, and serves as the bench-side checker in loopback builds.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868. Clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 4. Byte FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- `io_mainClk`  in  1  System clock; all logic is on the rising edge.
- `io_asyncReset`  in  1  Reset, asynchronous and active-high.
- `io_uart_rxd`  in  1  Serial line. Asynchronous to the clock; idles high.
- `io_data`  out  8  FIFO head byte. Valid only while `io_valid` = 1.
- `io_valid`  out  1  FIFO not empty.
- `io_ready`  in  1  Consumer accepts the head byte when `io_valid & io_ready`.
- `io_count`  out  clog2(FIFO_DEPTH)+1  Current FIFO occupancy.
- `io_frameError`  out  1  One-cycle pulse when a stop bit is sampled low.
- `io_overflow`  out  1  Sticky. Set when a received byte is dropped because the FIFO is full.
- `io_clearErrors`  in  1  Synchronous clear of `io_overflow`.

## Operation
- **Synchronizer:** `io_uart_rxd` passes through a 2-FF synchronizer. Its reset value is 1 (idle). The state machine sees only the synchronized signal `rxs`.
- **Bit counter:** counts 0..CLKS_PER_BIT-1. Let H = CLKS_PER_BIT/2, truncated.
- **State machine:**
  - IDLE: when `rxs` = 0, clear the counter and go to START.
  - START: at count H-1, sample `rxs`. If 1, treat it as a glitch and return to IDLE. If 0, go to DATA with bit index 0.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, into the shift register. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles. If `rxs` = 1, push the byte and return to IDLE. If `rxs` = 0, pulse `io_frameError`, push nothing, and go to BREAK.
  - BREAK: wait for `rxs` = 1, then go to IDLE. A held-low line therefore yields exactly one error and no bytes.
- **Stop bit:** it is sampled mid-bit and IDLE is re-entered immediately, so back-to-back frames with a single stop bit are received.
- **FIFO:** circular buffer with read/write pointers one bit wider than the address.
  - `io_valid` = (count ≠ 0). `io_data` shows the head entry combinationally from storage.
  - Pop on `io_valid & io_ready`.
  - Push while full (no pop in the same cycle): the byte is dropped, `io_overflow` sets, and the contents are unchanged.
  - Push and pop in the same cycle while full: both take effect, no overflow, count unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect. The byte is not bypassed, and `io_valid` rises next cycle.
- **Error clear:** `io_clearErrors` clears `io_overflow`. If an overflow occurs in the same cycle, set wins.
- **Reset:** applies asynchronously at any time, including mid-frame.
  - State → IDLE; counters and pointers → 0; `io_count` = 0; `io_valid` = 0; `io_data` = 0x00; `io_frameError` = 0; `io_overflow` = 0; synchronizer = 1.
  - A frame in progress is discarded. Reception resumes on the next falling edge after release.

## Timing
- The falling edge of the start bit is seen in IDLE 2 cycles after it appears on `io_uart_rxd`.
- Samples fall at H, H+C, …, H+9C cycles after IDLE detects `rxs` = 0, where C = CLKS_PER_BIT.
- `io_valid` rises in the cycle after the stop sample. Total latency from the start edge on the pin to `io_valid` is 3 + H + 9C cycles.
- `io_frameError` is high for exactly the cycle after the stop sample.
- `io_count` and `io_valid` update in the cycle after a push or pop edge.
- With `io_ready` held high, a byte occupies the head for exactly 1 cycle.

## Test plan
Directed tests use CLKS_PER_BIT = 16 and FIFO_DEPTH = 4.
- **Single byte:** send 0xA5 (8N1) with `io_ready` = 0 → `io_valid` = 1 exactly 3+8+144 = 155 cycles after the start edge, `io_data` = 0xA5, `io_count` = 1; assert `io_ready` for 1 cycle → `io_count` = 0, `io_valid` = 0.
- **Back-to-back and overflow:** send 0x00, 0xFF, 0x55, 0x3C, 0x81 back-to-back with `io_ready` = 0 → first four bytes are stored in order, `io_count` = 4, `io_overflow` = 1; drain → 0x00, 0xFF, 0x55, 0x3C; pulse `io_clearErrors` → `io_overflow` = 0.
- **Glitch rejection:** drive a 4-cycle low pulse → no state change beyond START, no byte, no error. **Framing error:** send 0x12 with stop bit low → one-cycle `io_frameError`, no byte; the next frame 0x34 is received correctly after the line returns high.
- **Concurrent push/pop at full:** fill the FIFO, then hold `io_ready` = 1 while the next byte 0x77 completes → `io_count` stays 4, no overflow, 0x77 is last out.
- **Mid-frame reset:** assert `io_asyncReset` during bit 3 of a frame → all outputs return to their reset values immediately; the frame is discarded; the next frame 0xC3 is received correctly.
